// File: rtl/l1_gap_stats_pkg.sv
// Shared constants and state type for the layer-1 statistics stage.
// Layer-1 memory geometry, the 9.4 fixed-point data format and the controller states.
package l1_gap_stats_pkg;

    localparam logic [11:0] LAYER1_BASE = 12'h000;
    localparam int unsigned L1_N_PIX    = 1024;
    localparam int unsigned L1_LOG2_N   = 10;
    localparam int unsigned FRAC_BITS   = 4;
    localparam int unsigned DATA_W      = 13;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StDrain,
        StFinal,
        StDone
    } state_e;

endpackage

// File: rtl/l1_stat_acc.sv
// Running statistics over one pass of layer-1 data: sum, first arg-max and threshold count.
// A single accepted word updates all four accumulators in the same cycle.
module l1_stat_acc
    import l1_gap_stats_pkg::*;
#(
    parameter int unsigned        LOG2_N = L1_LOG2_N,
    parameter logic [DATA_W-1:0]  THRESH = DATA_W'(1 << FRAC_BITS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear_i,
    input  logic                     valid_i,
    input  logic [DATA_W-1:0]        data_i,
    input  logic [LOG2_N-1:0]        addr_i,
    output logic [LOG2_N+DATA_W-1:0] sum_o,
    output logic [DATA_W-1:0]        max_o,
    output logic [LOG2_N-1:0]        max_addr_o,
    output logic [LOG2_N:0]          cnt_o
);

    localparam int unsigned SumW = LOG2_N + DATA_W;

    logic [SumW-1:0]   sum_q, sum_d;
    logic [DATA_W-1:0] max_q, max_d;
    logic [LOG2_N-1:0] maxa_q, maxa_d;
    logic [LOG2_N:0]   cnt_q, cnt_d;

    always_comb begin
        sum_d  = sum_q;
        max_d  = max_q;
        maxa_d = maxa_q;
        cnt_d  = cnt_q;
        if (clear_i) begin
            sum_d  = '0;
            max_d  = '0;
            maxa_d = '0;
            cnt_d  = '0;
        end else if (valid_i) begin
            sum_d = sum_q + SumW'(data_i);
            // Strict compare keeps the earliest address on ties.
            if (data_i > max_q) begin
                max_d  = data_i;
                maxa_d = addr_i;
            end
            if (data_i >= THRESH) begin
                cnt_d = cnt_q + (LOG2_N + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q  <= '0;
            max_q  <= '0;
            maxa_q <= '0;
            cnt_q  <= '0;
        end else begin
            sum_q  <= sum_d;
            max_q  <= max_d;
            maxa_q <= maxa_d;
            cnt_q  <= cnt_d;
        end
    end

    assign sum_o      = sum_q;
    assign max_o      = max_q;
    assign max_addr_o = maxa_q;
    assign cnt_o      = cnt_q;

endmodule

// File: rtl/l1_gap_stats.sv
// Streams the pooled layer-1 map out of memory and reports average, max, arg-max and
// count-above-threshold; results are published only once a full pass completes.
module l1_gap_stats
    import l1_gap_stats_pkg::*;
#(
    parameter int unsigned        N_PIX  = L1_N_PIX,
    parameter int unsigned        LOG2_N = L1_LOG2_N,
    parameter logic [DATA_W-1:0]  THRESH = DATA_W'(1 << FRAC_BITS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              crd,
    output logic              csel,
    output logic [11:0]       caddr_rd,
    input  logic [DATA_W-1:0] cdata_rd,
    output logic [DATA_W-1:0] avg_out,
    output logic [DATA_W-1:0] max_out,
    output logic [LOG2_N-1:0] max_addr,
    output logic [LOG2_N:0]   above_cnt
);

    localparam int unsigned SumW = LOG2_N + DATA_W;

    state_e            state_q, state_d;
    logic [LOG2_N-1:0] addr_q, addr_d;
    logic              vld_q;
    logic [LOG2_N-1:0] cap_addr_q;
    logic              accept;

    logic [SumW-1:0]   acc_sum;
    logic [DATA_W-1:0] acc_max;
    logic [LOG2_N-1:0] acc_maxa;
    logic [LOG2_N:0]   acc_cnt;

    assign accept = (state_q == StIdle) && start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRead;
                    addr_d  = '0;
                end
            end
            StRead: begin
                // Address wraps to zero after the last issue, leaving caddr_rd clean.
                addr_d = addr_q + LOG2_N'(1);
                if (addr_q == LOG2_N'(N_PIX - 1)) begin
                    state_d = StDrain;
                end
            end
            StDrain: state_d = StFinal;
            StFinal: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy     = (state_q == StRead) || (state_q == StDrain) || (state_q == StFinal);
        done     = (state_q == StDone);
        crd      = (state_q == StRead);
        csel     = crd;
        caddr_rd = LAYER1_BASE + 12'(addr_q);
    end

    // Data for the address issued in cycle t arrives during t+1; delay valid/addr to match.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q     <= '0;
            vld_q      <= 1'b0;
            cap_addr_q <= '0;
            avg_out    <= '0;
            max_out    <= '0;
            max_addr   <= '0;
            above_cnt  <= '0;
        end else begin
            addr_q     <= addr_d;
            vld_q      <= crd;
            cap_addr_q <= addr_q;
            if (accept) begin
                avg_out   <= '0;
                max_out   <= '0;
                max_addr  <= '0;
                above_cnt <= '0;
            end else if (state_q == StFinal) begin
                avg_out   <= acc_sum[SumW-1:LOG2_N];
                max_out   <= acc_max;
                max_addr  <= acc_maxa;
                above_cnt <= acc_cnt;
            end
        end
    end

    l1_stat_acc #(
        .LOG2_N (LOG2_N),
        .THRESH (THRESH)
    ) u_acc (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (accept),
        .valid_i    (vld_q),
        .data_i     (cdata_rd),
        .addr_i     (cap_addr_q),
        .sum_o      (acc_sum),
        .max_o      (acc_max),
        .max_addr_o (acc_maxa),
        .cnt_o      (acc_cnt)
    );

endmodule

// File: doc/l1_gap_stats.md
# l1_gap_stats

Layer-1 statistics stage, placed directly downstream of the atrous-conv/max-pool engine. After the engine has written the 32x32 pooled map into layer-1 memory (csel=1), this block streams all 1024 entries back out of that memory at one read per cycle. It produces four results, held stable for the host/classifier: the global average (global-average-pool output), the global maximum and its address, and the count of entries at or above a threshold.

## Interface
Parameters:
- N_PIX, 1024, number of layer-1 entries read (power of two)
- LOG2_N, 10, log2(N_PIX); used as address width and average shift
- THRESH, 13'h0010, compare threshold (1.0 in 9.4 fixed point)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until the cycle DONE is entered
- done  out  1  one-cycle pulse, results valid
- crd  out  1  layer-memory read enable
- csel  out  1  memory select; driven 1 while reading, 0 otherwise
- caddr_rd  out  12  read address; upper bits zero
- cdata_rd  in  13  read data, unsigned 9.4
- avg_out  out  13  sum >> LOG2_N (truncated)
- max_out  out  13  largest entry
- max_addr  out  10  address of first occurrence of max_out
- above_cnt  out  11  number of entries >= THRESH

## Operation
- Memory read latency: address/crd registered in cycle t; cdata_rd is sampled at the edge ending cycle t+1.
- States:
  - IDLE: on start, go to READ. caddr_rd<=0, crd<=1, csel<=1, busy<=1. Clear sum, max_out, max_addr, above_cnt.
  - READ: issue addresses 0..N_PIX-1, one per cycle. From the second READ cycle on, capture the data for the previous address.
  - After issuing address N_PIX-1, go to DRAIN. crd<=0, csel<=0.
  - DRAIN: capture the data for address N_PIX-1. Go to FINAL.
  - FINAL: avg_out<=sum[LOG2_N+12:LOG2_N]. Go to DONE.
  - DONE: done=1, busy=0. Go to IDLE.
- Per captured word:
  - sum += cdata_rd, using a LOG2_N+13 bit accumulator (23 bits), which cannot overflow.
  - If cdata_rd > max_out (strictly greater), update max_out and max_addr. Ties keep the earlier address.
  - If cdata_rd >= THRESH, increment above_cnt (11 bits, maximum 1024).
- Result outputs hold from DONE until the next accepted start. At start they clear and are undefined-but-stable (cleared values) until the next DONE.
- start while busy, in FINAL, or in DONE: ignored, not queued.
- cdata_rd is treated unsigned (post-ReLU data). No sign extension.

## Timing
- Reset values: busy=0, done=0, crd=0, csel=0, caddr_rd=0, avg_out=0, max_out=0, max_addr=0, above_cnt=0; state IDLE.
- Sequence, with start sampled at edge E0:
  - cycles 1..1024 issue addresses 0..1023
  - cycle 1025 is DRAIN
  - cycle 1026 is FINAL
  - cycle 1027 has done=1 and busy=0
- Total latency: 1027 cycles from the start edge to done.
- crd is high for exactly N_PIX consecutive cycles per run. caddr_rd increments by 1 each of those cycles.
- Reset asserted mid-run: all outputs return to their reset values immediately. No done pulse is produced, and no partial result is visible. A subsequent start runs cleanly from address 0.
- Back-to-back: start in the cycle after DONE (state IDLE) is accepted.

## Structure
- Shared package: LAYER1_BASE/N_PIX constants, fixed-point format constants (FRAC_BITS=4, DATA_W=13), and the state enum (IDLE, READ, DRAIN, FINAL, DONE).
- A natural sub-module is l1_stat_acc. It holds the sum, max, arg-max and threshold-count datapath, with clear/valid/data/addr inputs. The controller handles the address and handshake sequencing.

## Test plan
- All-zero memory, start -> done at cycle 1027, avg_out=0, max_out=0, max_addr=0, above_cnt=0. crd high for exactly 1024 cycles.
- All entries 13'h0010 -> avg_out=13'h0010, max_out=13'h0010, max_addr=0 (tie rule), above_cnt=1024.
- Only entry 517 set to 13'h0FF0, others 0 -> max_out=13'h0FF0, max_addr=517, avg_out=3, above_cnt=1.
- All entries 13'h1FFF -> avg_out=13'h1FFF, above_cnt=1024. No accumulator wrap.
- Reset asserted at cycle 500 of a run -> busy=0, crd=0, csel=0, no done. Restart then yields correct results.
- Second start pulse at cycle 10 of a run -> ignored. A single done occurs at cycle 1027 with correct results.
